jala_mem_responder: RTL
=======================

# jala_mem_responder

Memory-side responder for the JALA CPU's two memory request ports (port 1 and port 2, driven by the CPU's MemRead1/MemWrite1 and MemRead2/MemWrite2 controls). It accepts held read/write requests on both ports, arbitrates them onto one single-port synchronous RAM, and returns a one-cycle acknowledge with read data per port. It sits between the CPU integration top and the backing RAM macro, replacing the free dual-port memory model with a realistic single-port one.

## Interface
- ADDR_W, 10, RAM word-address width; RAM depth is 2^ADDR_W 16-bit words
- CLK  in  1  system clock, all state updates on rising edge
- RstN  in  1  reset; asynchronous, active-low
- Req1Read / Req1Write  in  1 each  port-1 read / write request, held until Ack1
- Req1Addr  in  16  port-1 word address
- Req1WData  in  16  port-1 write data
- Ack1  out  1  port-1 completion pulse, one cycle
- Rsp1RData  out  16  port-1 read data, valid while Ack1=1 and held until next port-1 read completes
- Req2Read, Req2Write, Req2Addr, Req2WData, Ack2, Rsp2RData: same as port 1 for port 2
- RamEn  out  1  RAM access strobe
- RamWe  out  1  RAM write enable (meaningful only with RamEn)
- RamAddr  out  ADDR_W  RAM address
- RamWData  out  16  RAM write data
- RamRData  in  16  RAM read data, valid the cycle after the RamEn/!RamWe cycle
- Busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ACCESS, RDWAIT, ACK. All outputs registered or decoded from state registers.
- IDLE: if any port has Read or Write high, grant one port; latch port id, op (write if ReqNWrite, else read), Addr[ADDR_W-1:0], WData; go ACCESS. Else stay.
- Both Read and Write high on one port: treated as write.
- ACCESS: RamEn=1, RamWe=op, RamAddr/RamWData from latches. Write -> ACK; read -> RDWAIT.
- RDWAIT: capture RamRData into granted port's RspNRData at exit edge; go ACK.
- ACK: granted port's AckN=1; the other Ack stays 0; go IDLE.
- Address bits [15:ADDR_W] ignored; addresses alias modulo 2^ADDR_W.
- Request inputs sampled only in IDLE; changes during ACCESS/RDWAIT/ACK have no effect.
- Arbitration per Configuration; pointer updates on every grant.
- Reset (any time, including mid-access): state IDLE, Ack1=Ack2=0, RamEn=RamWe=0, RamAddr=0, RamWData=0, Rsp1RData=Rsp2RData=0, Busy=0, last-grant pointer = port 2 (so port 1 wins first tie). In-flight access is dropped, no Ack.

## Timing
- Request high before edge E0 with FSM in IDLE -> grant at E0.
- Write: RamEn/RamWe high E0-E1; Ack high E1-E2. Throughput 3 cycles per write.
- Read: RamEn high E0-E1; RamRData valid E1-E2 and captured at E2; Ack and RspNRData valid E2-E3. Throughput 4 cycles per read.
- Requester must drop or change its request at the edge ending the Ack cycle; a request still high at the following IDLE edge is a new request.
- Losing port's request waits; it is granted at the IDLE edge after the winner's Ack cycle, no idle gap beyond the IDLE state cycle.
- No combinational path from any input to any output.

## Configuration
- JALA_MEM_RR_ARB_EN defined: round-robin; on simultaneous requests the port not granted last wins.
- Not defined: fixed priority; port 1 always wins simultaneous requests (port 2 can starve). Pointer register removed.

## Test plan
- Reset value check: RstN=0 mid-read (state RDWAIT) -> all outputs 0 next sample, no Ack1/Ack2 ever for that request, Busy=0.
- Port-1 write addr 0x0005 data 0xBEEF, then port-1 read 0x0005 -> write Ack1 one cycle after grant; read Ack1 two cycles after grant with Rsp1RData=0xBEEF.
- Alias: port-2 write 0x0405 data 0x1234 (ADDR_W=10), port-1 read 0x0005 -> Rsp1RData=0x1234.
- Simultaneous port-1 read and port-2 write held continuously -> with JALA_MEM_RR_ARB_EN grants alternate 1,2,1,2; without it port 1 granted every time.
- Port-1 Read and Write both high, addr 0x0010 data 0x00FF -> RamWe=1, later read of 0x0010 returns 0x00FF.
- Request addr/data changed during ACCESS -> RAM sees latched original values; Rsp2RData unchanged on port-1 completions.

Source files
------------

// File: rtl/jala_mem_responder.sv
// Single-port RAM responder for the JALA CPU's two memory request ports.
// Optional macro JALA_MEM_RR_ARB_EN selects round-robin arbitration; default is fixed priority (port 1 wins).
module jala_mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RstN,
    input  logic              Req1Read,
    input  logic              Req1Write,
    input  logic [15:0]       Req1Addr,
    input  logic [15:0]       Req1WData,
    output logic              Ack1,
    output logic [15:0]       Rsp1RData,
    input  logic              Req2Read,
    input  logic              Req2Write,
    input  logic [15:0]       Req2Addr,
    input  logic [15:0]       Req2WData,
    output logic              Ack2,
    output logic [15:0]       Rsp2RData,
    output logic              RamEn,
    output logic              RamWe,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [15:0]       RamWData,
    input  logic [15:0]       RamRData,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               port_q, port_d;     // 0 = port 1, 1 = port 2
    logic               op_q, op_d;         // 1 = write
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rsp1_q, rsp1_d;
    logic [15:0]        rsp2_q, rsp2_d;
    logic               req1, req2, grant2;

`ifdef JALA_MEM_RR_ARB_EN
    logic               last_q, last_d;     // 1 = port 2 granted last
`endif

    // High address bits alias away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Req1Addr[15:ADDR_W], Req2Addr[15:ADDR_W]};

    assign req1 = Req1Read | Req1Write;
    assign req2 = Req2Read | Req2Write;

`ifdef JALA_MEM_RR_ARB_EN
    assign grant2 = req2 & (~req1 | ~last_q);
`else
    assign grant2 = req2 & ~req1;
`endif

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsp1_d  = rsp1_q;
        rsp2_d  = rsp2_q;
`ifdef JALA_MEM_RR_ARB_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req1 || req2) begin
                    port_d  = grant2;
                    op_d    = grant2 ? Req2Write : Req1Write;
                    addr_d  = grant2 ? Req2Addr[ADDR_W-1:0] : Req1Addr[ADDR_W-1:0];
                    wdata_d = grant2 ? Req2WData : Req1WData;
`ifdef JALA_MEM_RR_ARB_EN
                    last_d  = grant2;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = op_q ? ACK : RDWAIT;
            RDWAIT: begin
                if (port_q) begin
                    rsp2_d = RamRData;
                end else begin
                    rsp1_d = RamRData;
                end
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Data latches are reset too so the RAM-facing outputs read zero after reset.
    always_ff @(posedge CLK or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp1_q  <= '0;
            rsp2_q  <= '0;
`ifdef JALA_MEM_RR_ARB_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsp1_q  <= rsp1_d;
            rsp2_q  <= rsp2_d;
`ifdef JALA_MEM_RR_ARB_EN
            last_q  <= last_d;
`endif
        end
    end

    assign RamEn     = (state_q == ACCESS);
    assign RamWe     = (state_q == ACCESS) & op_q;
    assign RamAddr   = addr_q;
    assign RamWData  = wdata_q;
    assign Ack1      = (state_q == ACK) & ~port_q;
    assign Ack2      = (state_q == ACK) & port_q;
    assign Rsp1RData = rsp1_q;
    assign Rsp2RData = rsp2_q;
    assign Busy      = (state_q != IDLE);

endmodule
